// File: rtl/pulse_pair_gen_pkg.sv
// Shared widths, delay limit and FSM encoding for the pulse-pair generator
// and the interval-measurement blocks.
package pulse_pair_gen_pkg;

   localparam int unsigned PPG_WIDTH     = 26;
   localparam int unsigned PPG_MAX_DELAY = 24_999_999;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ppg_state_e;

endpackage

// File: rtl/pulse_pair_gen_interval_counter.sv
// Elapsed-cycle counter with synchronous clear and count enable.
module interval_counter
   import pulse_pair_gen_pkg::*;
#(
   parameter int unsigned WIDTH = PPG_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pulse_pair_gen.sv
// Generates one pulse on out_a and one on out_b per accepted start, separated
// by a signed delay; the sign selects which output leads.
module pulse_pair_gen
   import pulse_pair_gen_pkg::*;
#(
   parameter int unsigned WIDTH     = PPG_WIDTH,
   parameter int unsigned MAX_DELAY = PPG_MAX_DELAY,
   parameter int unsigned PULSE_W   = 4
) (
   input  logic                    clk,
   input  logic                    clrn,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] delay,
   output logic                    out_a,
   output logic                    out_b,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_DELAY);
   localparam logic [WIDTH:0] PW_X  = (WIDTH+1)'(PULSE_W);

   ppg_state_e       state_q;
   logic             neg_q;
   logic [WIDTH-2:0] mag_q;
   logic             out_a_q, out_b_q, busy_q, done_q, err_q;

   logic [WIDTH-1:0] abs_v;
   logic [WIDTH-2:0] mag_d;
   logic             is_min, in_range, accept;
   logic [WIDTH-1:0] e;
   logic [WIDTH:0]   e1_x, mag_x, end_x;
   logic             last, lead_d, trail_d, cnt_en;

   always_comb begin
      abs_v    = delay[WIDTH-1] ? $unsigned(-delay) : $unsigned(delay);
      // Only the most negative value still has its top bit set after negation.
      is_min   = abs_v[WIDTH-1];
      mag_d    = abs_v[WIDTH-2:0];
      in_range = !is_min && ({2'b00, mag_d} <= MAX_X);
      accept   = (state_q == IDLE) && start && in_range;

      mag_x    = {2'b00, mag_q};
      end_x    = mag_x + PW_X;
      e1_x     = {1'b0, e} + (WIDTH+1)'(1);
      last     = (e1_x == end_x);
      lead_d   = (e1_x < PW_X);
      trail_d  = (e1_x >= mag_x) && (e1_x < end_x);
      cnt_en   = (state_q == RUN) && !last;
   end

   interval_counter #(
      .WIDTH (WIDTH)
   ) u_elapsed (
      .clk_i   (clk),
      .rst_ni  (clrn),
      .clr_i   (accept),
      .en_i    (cnt_en),
      .count_o (e)
   );

   // Outputs are registered from the elapsed value the counter will hold next.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= IDLE;
         neg_q   <= 1'b0;
         mag_q   <= '0;
         out_a_q <= 1'b0;
         out_b_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (in_range) begin
                     state_q <= RUN;
                     neg_q   <= delay[WIDTH-1];
                     mag_q   <= mag_d;
                     busy_q  <= 1'b1;
                     out_a_q <= !delay[WIDTH-1] || (mag_d == '0);
                     out_b_q <= delay[WIDTH-1] || (mag_d == '0);
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (last) begin
                  state_q <= DONE;
                  out_a_q <= 1'b0;
                  out_b_q <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  out_a_q <= neg_q ? trail_d : lead_d;
                  out_b_q <= neg_q ? lead_d : trail_d;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_a = out_a_q;
   assign out_b = out_b_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_pulse_pair_gen.sv
// Scoreboard bench for pulse_pair_gen: stimulus queues the expected per-cycle
// {out_a,out_b,busy,done,err} vectors, a monitor pops one per active cycle.
module tb_pulse_pair_gen;

   localparam int W    = 26;
   localparam int MAXD = 300;
   localparam int PW   = 4;

   typedef struct {
      logic [4:0] v;
      string      name;
   } exp_t;

   logic                clk = 1'b0;
   logic                clrn = 1'b1;
   logic                start = 1'b0;
   logic signed [W-1:0] delay = '0;
   logic                out_a, out_b, busy, done, err;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   pulse_pair_gen #(
      .WIDTH     (W),
      .MAX_DELAY (MAXD),
      .PULSE_W   (PW)
   ) dut (
      .clk   (clk),
      .clrn  (clrn),
      .start (start),
      .delay (delay),
      .out_a (out_a),
      .out_b (out_b),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      logic [4:0] obs;
      exp_t       e;
      obs = {out_a, out_b, busy, done, err};
      if (obs != 5'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_activity: got a/b/busy/done/err=%b expected nothing", obs);
         end else begin
            e = exp_q.pop_front();
            if (obs !== e.v) begin
               failures++;
               $display("FAIL %s: got a/b/busy/done/err=%b expected %b", e.name, obs, e.v);
            end
         end
      end
   end

   task automatic push_vec(input logic [4:0] v, input string name);
      exp_t e;
      e.v    = v;
      e.name = name;
      exp_q.push_back(e);
   endtask

   // Expected active cycles T+1.. for an in-range pair, or only the first n of them.
   task automatic push_pair(input int d, input int n, input string name);
      int   mag;
      logic neg, lead, trail, a, b;
      int   cnt;
      mag = (d < 0) ? -d : d;
      neg = (d < 0);
      cnt = 0;
      for (int k = 1; k <= mag + PW; k++) begin
         lead  = (k <= PW);
         trail = (k > mag) && (k <= mag + PW);
         a     = neg ? trail : lead;
         b     = neg ? lead : trail;
         if (n < 0 || cnt < n) push_vec({a, b, 1'b1, 1'b0, 1'b0}, name);
         cnt++;
      end
      if (n < 0 || cnt < n) push_vec(5'b00110, name);
   endtask

   task automatic check_vec(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout: %0d expected cycles never seen, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Called right after a rising edge; the start is accepted on the next edge.
   task automatic run(input int d, input bit exp_err, input bit hold, input string name);
      if (exp_err) push_vec(5'b00001, name);
      else         push_pair(d, -1, name);
      #1;
      start = 1'b1;
      delay = W'(d);
      @(posedge clk);
      #1;
      delay = W'(5);
      if (hold) begin
         repeat (3) @(posedge clk);
         #1;
      end
      start = 1'b0;
      drain(name);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   initial begin
      #2 clrn = 1'b0;
      #1 check_vec("async_reset", {out_a, out_b, busy, done, err}, 5'b0);
      repeat (3) @(posedge clk);
      #1 check_vec("reset_state", {out_a, out_b, busy, done, err}, 5'b0);
      @(negedge clk);
      clrn = 1'b1;
      @(posedge clk);

      run(10,        1'b0, 1'b0, "pos10");
      run(-3,        1'b0, 1'b0, "neg3_overlap");
      run(0,         1'b0, 1'b0, "zero");
      run(25000000,  1'b1, 1'b0, "err_big");
      run(-33554432, 1'b1, 1'b0, "err_most_neg");
      run(MAXD + 1,  1'b1, 1'b0, "err_max_plus1");
      run(-(MAXD+1), 1'b1, 1'b0, "err_neg_max_plus1");
      run(MAXD,      1'b0, 1'b1, "max_held_start");
      run(-MAXD,     1'b0, 1'b0, "neg_max");
      run(1,         1'b0, 1'b0, "pos1");
      run(PW,        1'b0, 1'b0, "abut");

      // Reset in the middle of a +10 pair: only cycles T+1..T+5 are ever seen.
      push_pair(10, 5, "reset_mid");
      #1;
      start = 1'b1;
      delay = W'(10);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 clrn = 1'b0;
      #1 check_vec("reset_mid_outputs", {out_a, out_b, busy, done, err}, 5'b0);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL reset_mid_prefix: %0d expected cycles unseen, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1 check_vec("reset_held", {out_a, out_b, busy, done, err}, 5'b0);
      @(negedge clk);
      #2 clrn = 1'b1;
      @(posedge clk);
      run(7,  1'b0, 1'b0, "after_reset");
      run(-6, 1'b0, 1'b0, "after_reset_neg");

      repeat (4) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL final_queue: %0d left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
